// File: rtl/wb_timer_pkg.sv
// Shared definitions for the Wishbone machine-timer slave.
// Register offsets, CTRL bit positions, decode enum, byte-lane merge.
package wb_timer_pkg;

  localparam logic [4:0] OFS_MTIME_LO = 5'h00;
  localparam logic [4:0] OFS_MTIME_HI = 5'h04;
  localparam logic [4:0] OFS_CMP_LO   = 5'h08;
  localparam logic [4:0] OFS_CMP_HI   = 5'h0C;
  localparam logic [4:0] OFS_CTRL     = 5'h10;
  localparam logic [4:0] OFS_PRESC    = 5'h14;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_IRQ = 1;

  typedef enum logic [2:0] {
    DEC_NONE,
    DEC_MTIME_LO,
    DEC_MTIME_HI,
    DEC_CMP_LO,
    DEC_CMP_HI,
    DEC_CTRL,
    DEC_PRESC
  } dec_t;

  function automatic logic [31:0] be_merge(
    input logic [31:0] old,
    input logic [31:0] dat,
    input logic [3:0]  sel
  );
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) r[8*i +: 8] = dat[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_timer_tick_gen.sv
// Tick source for mtime: EN gating plus optional prescaler.
// Prescaler present only with WB_TIMER_PRESCALER_EN defined.
module wb_timer_tick_gen
  import wb_timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  input  logic [15:0] presc,
  output logic        tick
);

`ifdef WB_TIMER_PRESCALER_EN
  logic [15:0] cnt;

  // tick on terminal count, so one tick every presc+1 enabled cycles
  assign tick = en & (cnt == presc);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 16'd1;
    end
  end
`else
  logic unused;
  assign unused = ^{clk, rst, clr, presc};
  assign tick   = en;
`endif

endmodule

// File: rtl/wb_timer_slave.sv
// Wishbone B4 pipelined RISC-V machine timer (mtime/mtimecmp, irq).
// Optional prescaler register enabled by WB_TIMER_PRESCALER_EN.
module wb_timer_slave
  import wb_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_8000,
  parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_stall_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [31:0] wb_dat_o,
  output logic        timer_irq_o
);

  dec_t        dec;
  logic        acc;
  logic        valid;
  logic        wr;
  logic        rd;
  logic        sel_any;
  logic        wr_lo;
  logic        wr_hi;
  logic        clr;
  logic        tick;
  logic [63:0] mtime;
  logic [63:0] cmp;
  logic [31:0] shadow;
  logic        en;
  logic [15:0] presc;
  logic        irq;
  logic        r_ack;
  logic        r_err;
  logic [31:0] rdata;

  assign acc     = wb_cyc_i & wb_stb_i;
  assign valid   = (dec != DEC_NONE);
  assign wr      = acc & valid & wb_we_i;
  assign rd      = acc & valid & ~wb_we_i;
  assign sel_any = |wb_sel_i;
  assign wr_lo   = wr & sel_any & (dec == DEC_MTIME_LO);
  assign wr_hi   = wr & sel_any & (dec == DEC_MTIME_HI);
  assign clr     = wr & ((dec == DEC_CTRL) | (dec == DEC_PRESC));

  always_comb begin
    dec = DEC_NONE;
    if (wb_adr_i[31:5] == BASE_ADDR[31:5] && wb_adr_i[1:0] == 2'b00) begin
      case (wb_adr_i[4:0])
        OFS_MTIME_LO: dec = DEC_MTIME_LO;
        OFS_MTIME_HI: dec = DEC_MTIME_HI;
        OFS_CMP_LO:   dec = DEC_CMP_LO;
        OFS_CMP_HI:   dec = DEC_CMP_HI;
        OFS_CTRL:     dec = DEC_CTRL;
`ifdef WB_TIMER_PRESCALER_EN
        OFS_PRESC:    dec = DEC_PRESC;
`endif
        default:      dec = DEC_NONE;
      endcase
    end
  end

  wb_timer_tick_gen u_tick (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .en    (en),
    .clr   (clr),
    .presc (presc),
    .tick  (tick)
  );

  // a write to either half wins over a same-cycle tick, no carry
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      mtime <= '0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) mtime[31:0]  <= be_merge(mtime[31:0], wb_dat_i, wb_sel_i);
      if (wr_hi) mtime[63:32] <= be_merge(mtime[63:32], wb_dat_i, wb_sel_i);
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cmp <= CMP_RESET;
      en  <= 1'b0;
    end else if (wr) begin
      if (dec == DEC_CMP_LO)
        cmp[31:0] <= be_merge(cmp[31:0], wb_dat_i, wb_sel_i);
      if (dec == DEC_CMP_HI)
        cmp[63:32] <= be_merge(cmp[63:32], wb_dat_i, wb_sel_i);
      if (dec == DEC_CTRL && wb_sel_i[0])
        en <= wb_dat_i[CTRL_EN];
    end
  end

`ifdef WB_TIMER_PRESCALER_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      presc <= '0;
    end else if (wr && dec == DEC_PRESC) begin
      presc <= be_merge({16'd0, presc}, wb_dat_i, wb_sel_i) & 32'h0000_FFFF;
    end
  end
`else
  assign presc = '0;
`endif

  // low-word read latches the high word so a LO/HI pair is coherent
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      shadow <= '0;
    end else if (rd && dec == DEC_MTIME_LO) begin
      shadow <= mtime[63:32];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      irq <= 1'b0;
    end else begin
      irq <= en & (mtime >= cmp);
    end
  end

  always_comb begin
    rdata = '0;
    unique case (dec)
      DEC_MTIME_LO: rdata = mtime[31:0];
      DEC_MTIME_HI: rdata = shadow;
      DEC_CMP_LO:   rdata = cmp[31:0];
      DEC_CMP_HI:   rdata = cmp[63:32];
      DEC_CTRL: begin
        rdata[CTRL_EN]  = en;
        rdata[CTRL_IRQ] = irq;
      end
      DEC_PRESC:    rdata = {16'd0, presc};
      default:      rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      r_ack    <= acc & valid;
      r_err    <= acc & ~valid;
      wb_dat_o <= rd ? rdata : 32'd0;
    end
  end

  assign wb_stall_o  = 1'b0;
  assign wb_ack_o    = r_ack & wb_cyc_i;
  assign wb_err_o    = r_err & wb_cyc_i;
  assign timer_irq_o = irq;

endmodule
